blit_bus: RTL and testbench

Address decoder and bus responder directly downstream of the 68000 CPU wrapper. Consumes the wrapper's single-cycle `cpu_req` transactions, decodes them into ROM, RAM or I/O regions and forwards each to a memory port or a peripheral port. Returns exactly one `cpu_ack` per request, with `cpu_err` set for unmapped addresses, ROM writes or downstream timeout; the wrapper converts that into DTACK or BERR. Also records the address and cause of the most recent bus error.

---
 rtl/blit_bus.sv | 125 ++++++++++++
 tb/tb_blit_bus.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/blit_bus.sv
// blit_bus: decodes CPU requests into ROM/RAM/IO ports, applies a downstream timeout and records the most recent bus error
module blit_bus #(
  parameter logic [23:0] ROM_BASE = 24'h000000,
  parameter int          ROM_LOG2 = 18,
  parameter logic [23:0] RAM_BASE = 24'h700000,
  parameter int          RAM_LOG2 = 18,
  parameter logic [23:0] IO_BASE  = 24'h060000,
  parameter int          IO_LOG2  = 16,
  parameter int          TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic [23:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  input  logic [1:0]  cpu_wstrb,
  input  logic        cpu_we,
  output logic        cpu_ack,
  output logic [15:0] cpu_rdata,
  output logic        cpu_err,
  output logic        mem_req,
  output logic        mem_rom,
  output logic [23:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic [1:0]  mem_wstrb,
  output logic        mem_we,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic        mem_abort,
  output logic        io_req,
  output logic [23:0] io_addr,
  output logic [15:0] io_wdata,
  output logic [1:0]  io_wstrb,
  output logic        io_we,
  input  logic        io_ack,
  input  logic [15:0] io_rdata,
  output logic        io_abort,
  output logic [23:0] err_addr,
  output logic [1:0]  err_cause
);
  typedef enum logic [1:0] {IDLE, MEM, IO, RESP} state_t;
  state_t state, state_n;
  logic [15:0] cnt, rdata;
  logic [23:0] addr;
  logic [15:0] wdata;
  logic [1:0]  wstrb, cause;
  logic        we, rom, err;
  logic        rom_hit, ram_hit, io_hit, busy, accept, ack, expire;
  assign rom_hit = (cpu_addr >> ROM_LOG2) == (ROM_BASE >> ROM_LOG2);
  assign ram_hit = (cpu_addr >> RAM_LOG2) == (RAM_BASE >> RAM_LOG2);
  assign io_hit  = (cpu_addr >> IO_LOG2) == (IO_BASE >> IO_LOG2);
  assign busy    = state == MEM || state == IO;
  // a request seen while the previous cpu_ack is still high is held off
  assign accept  = state == IDLE && cpu_req && !cpu_ack;
  assign ack     = state == MEM ? mem_ack : state == IO ? io_ack : 1'b0;
  assign expire  = busy && !ack && cnt == 16'd1;
  assign mem_rom   = rom;
  assign mem_addr  = addr;
  assign mem_wdata = wdata;
  assign mem_wstrb = wstrb;
  assign mem_we    = we;
  assign io_addr   = addr;
  assign io_wdata  = wdata;
  assign io_wstrb  = wstrb;
  assign io_we     = we;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    if (accept) state_n = rom_hit ? (cpu_we ? RESP : MEM) : ram_hit ? MEM : io_hit ? IO : RESP;
    else if (ack || expire) state_n = RESP;
    else if (state == RESP) state_n = IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      rdata <= '0;
      addr <= '0;
      wdata <= '0;
      wstrb <= '0;
      we <= 1'b0;
      rom <= 1'b0;
      err <= 1'b0;
      cause <= '0;
      mem_req <= 1'b0;
      io_req <= 1'b0;
      mem_abort <= 1'b0;
      io_abort <= 1'b0;
      cpu_ack <= 1'b0;
      cpu_err <= 1'b0;
      cpu_rdata <= '0;
      err_addr <= '0;
      err_cause <= '0;
    end else begin
      mem_req <= accept && state_n == MEM;
      io_req <= accept && state_n == IO;
      mem_abort <= expire && state == MEM;
      io_abort <= expire && state == IO;
      cpu_ack <= state == RESP;
      if (busy) cnt <= cnt - 16'd1;
      if (accept) begin
        addr <= cpu_addr;
        wdata <= cpu_wdata;
        wstrb <= cpu_wstrb;
        we <= cpu_we;
        rom <= rom_hit;
        cnt <= 16'(TIMEOUT);
        err <= state_n == RESP;
        cause <= rom_hit ? 2'd2 : 2'd1;
      end else if (ack) begin
        rdata <= state == MEM ? mem_rdata : io_rdata;
        err <= 1'b0;
      end else if (expire) begin
        err <= 1'b1;
        cause <= 2'd3;
      end
      cpu_err <= state == RESP && err;
      cpu_rdata <= state != RESP ? 16'h0000 : err ? 16'hFFFF : rdata;
      if (state == RESP && err) begin
        err_addr <= addr;
        err_cause <= cause;
      end
    end
endmodule

// File: tb/tb_blit_bus.sv
// tb_blit_bus: directed checks of decode, error responses, timeout and reset recovery for blit_bus
module tb_blit_bus;
  logic        clk = 0, rst = 1;
  logic        cpu_req = 0, cpu_we = 0;
  logic [23:0] cpu_addr = 0;
  logic [15:0] cpu_wdata = 0;
  logic [1:0]  cpu_wstrb = 0;
  logic        cpu_ack, cpu_err;
  logic [15:0] cpu_rdata;
  logic        mem_req, mem_rom, mem_we, mem_abort;
  logic [23:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [1:0]  mem_wstrb;
  logic        mem_ack = 0;
  logic [15:0] mem_rdata = 0;
  logic        io_req, io_we, io_abort;
  logic [23:0] io_addr;
  logic [15:0] io_wdata;
  logic [1:0]  io_wstrb;
  logic        io_ack = 0;
  logic [15:0] io_rdata = 0;
  logic [23:0] err_addr;
  logic [1:0]  err_cause;
  int n_chk = 0, n_fail = 0;

  blit_bus #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb), .cpu_we(cpu_we),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
    .mem_req(mem_req), .mem_rom(mem_rom), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_we(mem_we), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .mem_abort(mem_abort),
    .io_req(io_req), .io_addr(io_addr), .io_wdata(io_wdata), .io_wstrb(io_wstrb), .io_we(io_we),
    .io_ack(io_ack), .io_rdata(io_rdata), .io_abort(io_abort),
    .err_addr(err_addr), .err_cause(err_cause)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic req(input logic [23:0] a, input logic w, input logic [15:0] d, input logic [1:0] s);
    cpu_addr = a; cpu_we = w; cpu_wdata = d; cpu_wstrb = s; cpu_req = 1;
    step();
    cpu_req = 0;
  endtask

  task automatic outs_zero(input string tag);
    chk({tag, " ack/err/rdata"}, {cpu_ack, cpu_err, cpu_rdata}, 0);
    chk({tag, " mem ctl"}, {mem_req, mem_rom, mem_we, mem_abort, mem_wstrb}, 0);
    chk({tag, " mem addr/wdata"}, {mem_addr, mem_wdata[7:0]}, 0);
    chk({tag, " io ctl"}, {io_req, io_we, io_abort, io_wstrb, io_wdata}, 0);
    chk({tag, " io addr"}, io_addr, 0);
    chk({tag, " err"}, {err_cause, err_addr}, 0);
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    outs_zero("reset");
    rst = 0;
    step();
    // RAM read, ack sampled at E3
    req(24'h700010, 0, 16'h0, 2'b11);
    chk("ram mem_req", {mem_req, mem_rom, io_req}, 3'b100);
    chk("ram mem_addr", mem_addr, 24'h700010);
    step();
    chk("ram mem_req pulse", mem_req, 0);
    mem_ack = 1; mem_rdata = 16'h1234;
    step();
    mem_ack = 0; mem_rdata = 0;
    chk("ram ack early", cpu_ack, 0);
    step();
    chk("ram resp", {cpu_ack, cpu_err, cpu_rdata}, {2'b10, 16'h1234});
    step();
    chk("ram ack pulse", cpu_ack, 0);
    // ROM write
    req(24'h000100, 1, 16'hCAFE, 2'b01);
    chk("romwr no req", {mem_req, io_req, cpu_ack}, 0);
    step();
    chk("romwr resp", {cpu_ack, cpu_err, cpu_rdata, mem_req}, {2'b11, 16'hFFFF, 1'b0});
    chk("romwr err", {err_cause, err_addr}, {2'd2, 24'h000100});
    step();
    // unmapped read
    req(24'h300000, 0, 16'h0, 2'b11);
    chk("unmap no req", {mem_req, io_req}, 0);
    step();
    chk("unmap resp", {cpu_ack, cpu_err, cpu_rdata}, {2'b11, 16'hFFFF});
    chk("unmap err", {err_cause, err_addr}, {2'd1, 24'h300000});
    step();
    // ROM read, zero-wait
    req(24'h000200, 0, 16'h0, 2'b11);
    chk("rom mem_req", {mem_req, mem_rom}, 2'b11);
    mem_ack = 1; mem_rdata = 16'h4E71;
    step();
    mem_ack = 0;
    chk("rom ack early", cpu_ack, 0);
    step();
    chk("rom resp", {cpu_ack, cpu_err, cpu_rdata}, {2'b10, 16'h4E71});
    step();
    // IO write with no ack -> timeout after E4
    req(24'h060004, 1, 16'hBEEF, 2'b11);
    chk("io req", {io_req, mem_req, io_we, io_wstrb}, 5'b10111);
    chk("io addr/wdata", {io_addr, io_wdata}, {24'h060004, 16'hBEEF});
    step(); step(); step();
    chk("io no abort yet", {io_abort, cpu_ack}, 0);
    chk("io hold", {io_addr, io_wdata}, {24'h060004, 16'hBEEF});
    step();
    chk("io abort", {io_abort, mem_abort, cpu_ack}, 3'b100);
    step();
    chk("io to resp", {cpu_ack, cpu_err, cpu_rdata, io_abort}, {2'b11, 16'hFFFF, 1'b0});
    chk("io to err", {err_cause, err_addr}, {2'd3, 24'h060004});
    step();
    io_ack = 1; io_rdata = 16'h1111;
    step();
    io_ack = 0;
    step();
    chk("late io_ack", {cpu_ack, err_cause}, {1'b0, 2'd3});
    // ack coinciding with expiry
    req(24'h700020, 0, 16'h0, 2'b11);
    step(); step(); step();
    mem_ack = 1; mem_rdata = 16'h5A5A;
    step();
    mem_ack = 0;
    chk("race no abort", {mem_abort, cpu_ack}, 0);
    step();
    chk("race resp", {cpu_ack, cpu_err, cpu_rdata, mem_abort}, {2'b10, 16'h5A5A, 1'b0});
    chk("race err hold", err_cause, 2'd3);
    step();
    // IO read with ack
    req(24'h060010, 0, 16'h0, 2'b10);
    step();
    io_ack = 1; io_rdata = 16'h00C3;
    step();
    io_ack = 0;
    step();
    chk("io rd resp", {cpu_ack, cpu_err, cpu_rdata}, {2'b10, 16'h00C3});
    step();
    // reset mid-transaction
    req(24'h700030, 0, 16'h0, 2'b11);
    chk("rst pre req", mem_req, 1);
    step();
    rst = 1;
    #1;
    outs_zero("midrst");
    step();
    rst = 0;
    mem_ack = 1; mem_rdata = 16'h9999;
    step();
    mem_ack = 0;
    step();
    chk("post rst ack ignored", {cpu_ack, mem_abort}, 0);
    step(); step(); step();
    chk("post rst quiet", {cpu_ack, mem_abort, mem_req}, 0);
    req(24'h700040, 0, 16'h0, 2'b11);
    chk("recover req", {mem_req, mem_addr}, {1'b1, 24'h700040});
    mem_ack = 1; mem_rdata = 16'h7777;
    step();
    mem_ack = 0;
    step();
    chk("recover resp", {cpu_ack, cpu_err, cpu_rdata}, {2'b10, 16'h7777});
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
